memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Consumer end of the execute-stage output: accepts one execute_data_t bundle per handshake and performs the load or store on the data bus.
- Produces the memory_data_t bundle for writeback.
- Non-memory instructions pass through in one cycle.
- Memory instructions run a request/response FSM on the dbus, stalling upstream until the response returns.

Parameters:
XLEN, 64, data/address width
MISALIGN_CHECK, 1, when 1 a misaligned access is not issued to the bus and is flagged in the output

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
dataE  in  execute_data_t  bundle from the execute pipeline register (pc, raw_instr, alu_out, ctl, dst, valid, MemWriteData, rd1, rd2, imm_64, csr, csr_rdata)
in_valid  in  1  dataE holds a new instruction
in_ready  out  1  block can accept dataE this cycle
dreq_valid  out  1  bus request valid
dreq_addr  out  XLEN  request address (= dataE.alu_out)
dreq_size  out  3  0=B,1=H,2=W,3=D
dreq_strobe  out  8  byte enables; all 0 for a read
dreq_data  out  XLEN  store data shifted to byte lane
dresp_addr_ok  in  1  request accepted
dresp_data_ok  in  1  response complete
dresp_data  in  XLEN  read data, naturally aligned in 64-bit word
dataM  out  memory_data_t  registered bundle to writeback
out_valid  out  1  dataM valid this cycle
misalign  out  1  registered; set alongside out_valid for a flagged access

Behaviour:
Reset:
- reset low, asynchronous: FSM to IDLE; out_valid=0, misalign=0, dreq_valid=0, dataM all zero.
- in_ready=1 after release.
- Reset mid-transaction drops the access; a late dresp_* after release is ignored in IDLE.

Control decode:
- ctl.MemRead, ctl.MemWrite, ctl.mem_size[1:0], ctl.mem_unsigned.
- Both read and write set: read takes priority.

FSM states:
- IDLE, in_ready=1. Transitions on in_valid & dataE.valid:
  - non-memory op: dataM latched from dataE, writeback value = alu_out (csr_rdata when ctl.csr_write); out_valid=1 next cycle; stay IDLE; throughput 1/cycle.
  - memory op, aligned: latch bundle -> REQ.
  - memory op, misaligned with MISALIGN_CHECK=1: no bus access; out_valid=1 and misalign=1 next cycle; stay IDLE.
  - in_valid with dataE.valid=0 (bubble): out_valid=0 next cycle.
- REQ: dreq_valid=1; addr/size/strobe/data held stable, in_ready=0.
  - addr_ok & data_ok same cycle -> DONE.
  - addr_ok only -> WAIT.
- WAIT: dreq_valid=0; data_ok -> DONE, capturing dresp_data.
- DONE: load result written into dataM; out_valid=1 for exactly one cycle; -> IDLE; in_ready=1 in DONE, so back-to-back accept is allowed.

Load/store data:
- Alignment: B any; H addr[0]=0; W addr[1:0]=0; D addr[2:0]=0.
- Strobe:
  - B: 1<<addr[2:0]
  - H: 3<<addr[2:0]
  - W: 8'h0F<<addr[2:0]
  - D: 8'hFF
- dreq_data = MemWriteData << (8*addr[2:0]).
- Load extract: dresp_data >> (8*addr[2:0]), truncated to size; sign-extended to 64 unless mem_unsigned.
- Store writeback value = alu_out; dst carried unchanged.

Outputs:
- out_valid low whenever not finishing an instruction.
- dataM holds its last value between valids.

Test Plan:
- ALU op, alu_out=0x1234, dst=5, three consecutive in_valid -> out_valid on 3 consecutive cycles, dataM value 0x1234, in_ready stays 1.
- LB, addr 0x80000003, dresp_data=0x00000000_80000000 with addr_ok+data_ok in same cycle -> dreq_size=0, strobe=0; dataM value 0xFFFFFFFF_FFFFFF80 two cycles after acceptance; LBU variant -> 0x80.
- SW, addr 0x80000004, MemWriteData=0xDEADBEEF, addr_ok at cycle 2, data_ok at cycle 5 -> strobe=8'hF0, dreq_data=0xDEADBEEF_00000000 held until addr_ok; in_ready=0 until DONE; single out_valid.
- LD at addr 0x80000004 with MISALIGN_CHECK=1 -> dreq_valid never rises; out_valid=1, misalign=1 next cycle.
- Assert reset in WAIT, then release and pulse dresp_data_ok -> outputs zero, FSM IDLE, no out_valid generated.
- Bubble (dataE.valid=0) between two LW ops, each with a 2-cycle bus latency -> correct data per op, no out_valid for the bubble.

Source files
------------

// File: rtl/memory_access.sv
`default_nettype none
// ============================================================================
// Module      : memory_access
// Description : Memory stage. Accepts one execute bundle per handshake.
//               Non-memory ops complete in one cycle. Loads and stores run a
//               request/response sequence on the data bus and stall upstream
//               until the response returns. The writeback bundle is
//               registered.
// Revision    : 1.0 - initial release
// ============================================================================

package memory_access_pkg;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] mem_size;      // 0=B 1=H 2=W 3=D
    logic       mem_unsigned;
    logic       csr_write;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic [63:0] alu_out;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic        valid;
    logic [63:0] MemWriteData;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm_64;
    logic [11:0] csr;
    logic [63:0] csr_rdata;
  } execute_data_t;

  // Operand and CSR fields travel with the instruction for trace/commit use.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    ctl_t        ctl;
    logic [4:0]  dst;
    logic        valid;
    logic [63:0] wb_data;
    logic [63:0] mem_addr;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm_64;
    logic [11:0] csr;
    logic [63:0] csr_rdata;
  } memory_data_t;

endpackage

module memory_access
  import memory_access_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  execute_data_t       dataE,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                dreq_valid,
  output logic [XLEN-1:0]     dreq_addr,
  output logic [2:0]          dreq_size,
  output logic [7:0]          dreq_strobe,
  output logic [XLEN-1:0]     dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [XLEN-1:0]     dresp_data,
  output memory_data_t        dataM,
  output logic                out_valid,
  output logic                misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  memory_data_t    pend_q;
  memory_data_t    dataM_q;
  logic            out_valid_q;
  logic            misalign_q;
  logic            dreq_valid_q;
  logic [XLEN-1:0] dreq_addr_q;
  logic [2:0]      dreq_size_q;
  logic [7:0]      dreq_strobe_q;
  logic [XLEN-1:0] dreq_data_q;

  // Decode of the incoming bundle
  logic [2:0]      off_e;
  logic            is_mem_e;
  logic            aligned_e;
  logic            misalign_e;
  logic [7:0]      strobe_e;
  logic [XLEN-1:0] wdata_e;
  logic [63:0]     alu_wb_e;
  memory_data_t    nonmem_d;

  // Completion of a pending access
  logic [2:0]      off_p;
  logic [XLEN-1:0] shifted_p;
  logic [XLEN-1:0] load_d;
  memory_data_t    finish_d;

  // DONE behaves like IDLE for acceptance so loads can issue back-to-back.
  assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE);

  function automatic memory_data_t pack_m(input execute_data_t e, input logic [63:0] wb);
    memory_data_t m;
    m.pc        = e.pc;
    m.raw_instr = e.raw_instr;
    m.ctl       = e.ctl;
    m.dst       = e.dst;
    m.valid     = e.valid;
    m.wb_data   = wb;
    m.mem_addr  = e.alu_out;
    m.rd1       = e.rd1;
    m.rd2       = e.rd2;
    m.imm_64    = e.imm_64;
    m.csr       = e.csr;
    m.csr_rdata = e.csr_rdata;
    return m;
  endfunction

  // Alignment, byte enables and lane-shifted store data for the incoming op
  always_comb begin
    off_e     = dataE.alu_out[2:0];
    is_mem_e  = dataE.ctl.MemRead | dataE.ctl.MemWrite;
    aligned_e = 1'b1;
    strobe_e  = 8'hFF;
    case (dataE.ctl.mem_size)
      2'd0: begin aligned_e = 1'b1;             strobe_e = 8'h01 << off_e; end
      2'd1: begin aligned_e = ~off_e[0];        strobe_e = 8'h03 << off_e; end
      2'd2: begin aligned_e = (off_e[1:0] == 2'b00); strobe_e = 8'h0F << off_e; end
      default: begin aligned_e = (off_e == 3'b000); strobe_e = 8'hFF; end
    endcase
    // Reads take priority over writes and never enable bytes.
    if (dataE.ctl.MemRead) strobe_e = 8'h00;
    misalign_e = is_mem_e & ~aligned_e & MISALIGN_CHECK;
    wdata_e    = dataE.MemWriteData << {off_e, 3'b000};
    alu_wb_e   = dataE.ctl.csr_write ? dataE.csr_rdata : dataE.alu_out;
    nonmem_d   = pack_m(dataE, alu_wb_e);
  end

  // Load extraction from the response word and final writeback bundle
  always_comb begin
    off_p     = pend_q.mem_addr[2:0];
    shifted_p = dresp_data >> {off_p, 3'b000};
    case (pend_q.ctl.mem_size)
      2'd0: load_d = pend_q.ctl.mem_unsigned ? {{(XLEN-8){1'b0}}, shifted_p[7:0]}
                                             : {{(XLEN-8){shifted_p[7]}}, shifted_p[7:0]};
      2'd1: load_d = pend_q.ctl.mem_unsigned ? {{(XLEN-16){1'b0}}, shifted_p[15:0]}
                                             : {{(XLEN-16){shifted_p[15]}}, shifted_p[15:0]};
      2'd2: load_d = pend_q.ctl.mem_unsigned ? {{(XLEN-32){1'b0}}, shifted_p[31:0]}
                                             : {{(XLEN-32){shifted_p[31]}}, shifted_p[31:0]};
      default: load_d = shifted_p;
    endcase
    finish_d = pend_q;
    if (pend_q.ctl.MemRead) finish_d.wb_data = load_d;
  end

  // Control FSM with registered bus request and writeback outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      pend_q        <= '0;
      dataM_q       <= '0;
      out_valid_q   <= 1'b0;
      misalign_q    <= 1'b0;
      dreq_valid_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_size_q   <= 3'd0;
      dreq_strobe_q <= 8'h00;
      dreq_data_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (in_valid && dataE.valid) begin
            if (!is_mem_e) begin
              dataM_q     <= nonmem_d;
              out_valid_q <= 1'b1;
            end else if (misalign_e) begin
              dataM_q     <= pack_m(dataE, dataE.alu_out);
              out_valid_q <= 1'b1;
              misalign_q  <= 1'b1;
            end else begin
              pend_q        <= pack_m(dataE, dataE.alu_out);
              dreq_valid_q  <= 1'b1;
              dreq_addr_q   <= dataE.alu_out;
              dreq_size_q   <= {1'b0, dataE.ctl.mem_size};
              dreq_strobe_q <= strobe_e;
              dreq_data_q   <= wdata_e;
              state_q       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dresp_addr_ok) begin
            dreq_valid_q <= 1'b0;
            if (dresp_data_ok) begin
              dataM_q     <= finish_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dresp_data_ok) begin
            dataM_q     <= finish_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dataM       = dataM_q;
  assign out_valid   = out_valid_q;
  assign misalign    = misalign_q;
  assign dreq_valid  = dreq_valid_q;
  assign dreq_addr   = dreq_addr_q;
  assign dreq_size   = dreq_size_q;
  assign dreq_strobe = dreq_strobe_q;
  assign dreq_data   = dreq_data_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access
// Description : Directed self-checking bench for memory_access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access;
  import memory_access_pkg::*;

  logic          clk;
  logic          reset;
  execute_data_t dataE;
  logic          in_valid;
  logic          in_ready;
  logic          dreq_valid;
  logic [63:0]   dreq_addr;
  logic [2:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_addr_ok;
  logic          dresp_data_ok;
  logic [63:0]   dresp_data;
  memory_data_t  dataM;
  logic          out_valid;
  logic          misalign;

  int n_checks = 0;
  int n_errors = 0;

  memory_access #(.XLEN(64), .MISALIGN_CHECK(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .dataE         (dataE),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .dataM         (dataM),
    .out_valid     (out_valid),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [63:0] alu, input logic [63:0] wd,
                        input logic [4:0] dst);
    dataE                  = '0;
    dataE.pc               = 64'h0000_0000_0000_1000;
    dataE.raw_instr        = 32'h0000_0013;
    dataE.alu_out          = alu;
    dataE.ctl.RegWrite     = rd | ~wr;
    dataE.ctl.MemRead      = rd;
    dataE.ctl.MemWrite     = wr;
    dataE.ctl.mem_size     = sz;
    dataE.ctl.mem_unsigned = uns;
    dataE.dst              = dst;
    dataE.valid            = v;
    dataE.MemWriteData     = wd;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    dresp_data = '0;
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0, 5'd0);

    // Reset state
    #2;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_misalign", {63'b0, misalign}, 64'd0);
    chk("rst_dreq_valid", {63'b0, dreq_valid}, 64'd0);
    chk("rst_dataM_wb", dataM.wb_data, 64'd0);
    chk("rst_dataM_dst", {59'b0, dataM.dst}, 64'd0);
    #10 reset = 1'b1;
    tick();
    chk("post_rst_in_ready", {63'b0, in_ready}, 64'd1);

    // ALU op accepted three cycles in a row
    set_op(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h1234, 64'h0, 5'd5);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("alu_out_valid", {63'b0, out_valid}, 64'd1);
      chk("alu_wb", dataM.wb_data, 64'h1234);
      chk("alu_dst", {59'b0, dataM.dst}, 64'd5);
      chk("alu_in_ready", {63'b0, in_ready}, 64'd1);
    end
    // CSR op writes back csr_rdata
    dataE.ctl.csr_write = 1'b1;
    dataE.csr_rdata     = 64'hCAFE;
    tick();
    chk("csr_wb", dataM.wb_data, 64'hCAFE);
    in_valid = 1'b0;
    tick();
    chk("idle_out_valid", {63'b0, out_valid}, 64'd0);
    chk("idle_dataM_hold", dataM.wb_data, 64'hCAFE);

    // LB and LBU at 0x80000003 with single-cycle response
    for (int u = 0; u < 2; u++) begin
      set_op(1'b1, 1'b1, 1'b0, 2'd0, u[0], 64'h8000_0003, 64'h0, 5'd7);
      in_valid = 1'b1;
      tick();
      chk("lb_dreq_valid", {63'b0, dreq_valid}, 64'd1);
      chk("lb_dreq_size", {61'b0, dreq_size}, 64'd0);
      chk("lb_dreq_strobe", {56'b0, dreq_strobe}, 64'd0);
      chk("lb_dreq_addr", dreq_addr, 64'h8000_0003);
      chk("lb_in_ready", {63'b0, in_ready}, 64'd0);
      chk("lb_no_early_out", {63'b0, out_valid}, 64'd0);
      in_valid = 1'b0;
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
      dresp_data = 64'h0000_0000_8000_0000;
      tick();
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      chk("lb_out_valid", {63'b0, out_valid}, 64'd1);
      chk("lb_wb", dataM.wb_data, (u == 0) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
      chk("lb_dreq_drop", {63'b0, dreq_valid}, 64'd0);
      chk("lb_done_ready", {63'b0, in_ready}, 64'd1);
      tick();
      chk("lb_single_out", {63'b0, out_valid}, 64'd0);
    end

    // SW at 0x80000004, delayed addr_ok and data_ok; ALU op waits behind it
    set_op(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 64'h8000_0004, 64'hDEAD_BEEF, 5'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sw_strobe", {56'b0, dreq_strobe}, 64'hF0);
    chk("sw_data", dreq_data, 64'hDEAD_BEEF_0000_0000);
    chk("sw_size", {61'b0, dreq_size}, 64'd2);
    tick();
    chk("sw_hold_valid", {63'b0, dreq_valid}, 64'd1);
    chk("sw_hold_data", dreq_data, 64'hDEAD_BEEF_0000_0000);
    chk("sw_hold_strobe", {56'b0, dreq_strobe}, 64'hF0);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    chk("sw_wait_dreq", {63'b0, dreq_valid}, 64'd0);
    chk("sw_wait_ready", {63'b0, in_ready}, 64'd0);
    set_op(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h5555, 64'h0, 5'd9);
    in_valid = 1'b1;
    tick();
    chk("sw_wait_no_out", {63'b0, out_valid}, 64'd0);
    chk("sw_wait_ready2", {63'b0, in_ready}, 64'd0);
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    chk("sw_out_valid", {63'b0, out_valid}, 64'd1);
    chk("sw_wb", dataM.wb_data, 64'h8000_0004);
    chk("sw_misalign", {63'b0, misalign}, 64'd0);
    tick();
    in_valid = 1'b0;
    chk("b2b_out_valid", {63'b0, out_valid}, 64'd1);
    chk("b2b_wb", dataM.wb_data, 64'h5555);
    tick();
    chk("b2b_end", {63'b0, out_valid}, 64'd0);

    // SH at offset 2
    set_op(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 64'h1_0000_0002, 64'hABCD, 5'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sh_strobe", {56'b0, dreq_strobe}, 64'h0C);
    chk("sh_data", dreq_data, 64'h0000_0000_ABCD_0000);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    chk("sh_out_valid", {63'b0, out_valid}, 64'd1);

    // Misaligned LD
    set_op(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h8000_0004, 64'h0, 5'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mis_out_valid", {63'b0, out_valid}, 64'd1);
    chk("mis_flag", {63'b0, misalign}, 64'd1);
    chk("mis_no_dreq", {63'b0, dreq_valid}, 64'd0);
    chk("mis_ready", {63'b0, in_ready}, 64'd1);
    tick();
    chk("mis_clear_out", {63'b0, out_valid}, 64'd0);
    chk("mis_clear_flag", {63'b0, misalign}, 64'd0);
    chk("mis_no_dreq2", {63'b0, dreq_valid}, 64'd0);

    // Reset while waiting for data
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0008, 64'h0, 5'd4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    chk("rw_in_wait", {63'b0, in_ready}, 64'd0);
    reset = 1'b0;
    #1;
    chk("rw_dataM_zero", dataM.wb_data, 64'd0);
    chk("rw_out_zero", {63'b0, out_valid}, 64'd0);
    chk("rw_dreq_zero", {63'b0, dreq_valid}, 64'd0);
    reset = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 64'h1111_2222_3333_4444;
    tick();
    dresp_data_ok = 1'b0;
    chk("rw_late_resp_out", {63'b0, out_valid}, 64'd0);
    chk("rw_idle_ready", {63'b0, in_ready}, 64'd1);
    chk("rw_late_dataM", dataM.wb_data, 64'd0);
    chk("rw_late_dreq", {63'b0, dreq_valid}, 64'd0);

    // Two LW ops with a bubble between them
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0000, 64'h0, 5'd10);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lwa_addr", dreq_addr, 64'h8000_0000);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data = 64'h1122_3344_8899_AABB;
    tick();
    dresp_data_ok = 1'b0;
    chk("lwa_out_valid", {63'b0, out_valid}, 64'd1);
    chk("lwa_wb", dataM.wb_data, 64'hFFFF_FFFF_8899_AABB);
    set_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h9999, 64'h0, 5'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("bubble_out_valid", {63'b0, out_valid}, 64'd0);
    chk("bubble_hold", dataM.wb_data, 64'hFFFF_FFFF_8899_AABB);
    set_op(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0, 5'd11);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lwb_strobe", {56'b0, dreq_strobe}, 64'h00);
    chk("lwb_size", {61'b0, dreq_size}, 64'd2);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data = 64'h7ABB_CCDD_0000_0000;
    tick();
    dresp_data_ok = 1'b0;
    chk("lwb_out_valid", {63'b0, out_valid}, 64'd1);
    chk("lwb_wb", dataM.wb_data, 64'h0000_0000_7ABB_CCDD);
    chk("lwb_dst", {59'b0, dataM.dst}, 64'd11);
    tick();
    chk("lwb_end", {63'b0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
